// File: rtl/i2s_slave_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_slave_transmitter
//
// Slave-side I2S transmitter. An external master supplies sclk and ws; this
// block shifts stereo samples out on sd_tx, MSB first. Sample pairs arrive over
// a valid/ready interface into a small FIFO. Each FIFO entry holds one
// {left, right} pair.
//
// sclk and ws are synchronised into the clk domain. Every falling edge of the
// synchronised sclk ("fall") shifts one bit out and samples ws. A ws 1->0 change
// starts a frame: the next pair is popped, left goes to the shifter and right is
// parked in hold_r until ws goes 0->1.
//
// Configuration macro:
//   I2S_SLAVE_TX_LJ_EN  defined   : left-justified, MSB driven at the ws-change fall
//                       undefined : Philips I2S, MSB one sclk after the ws change
//
// Ports:
//   clk          in   system clock (half sclk period > SYNC_STAGES+2 cycles)
//   rst          in   asynchronous active-low reset
//   sclk         in   serial clock from master (asynchronous)
//   ws           in   word select from master, 0=left 1=right (asynchronous)
//   sd_tx        out  serial data to master
//   in_data_l    in   left sample
//   in_data_r    in   right sample
//   in_valid     in   pair valid
//   in_ready     out  FIFO not full
//   frame_start  out  1-cycle pulse when a left word is loaded
//   underrun     out  1-cycle pulse when a frame starts with the FIFO empty
//   active       out  high while in the RUN state
// -----------------------------------------------------------------------------
module i2s_slave_transmitter #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             ws,
   output logic             sd_tx,
   input  logic [WIDTH-1:0] in_data_l,
   input  logic [WIDTH-1:0] in_data_r,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             frame_start,
   output logic             underrun,
   output logic             active
);

   // FIFO_DEPTH is a power of two and at least 2, so AW >= 1.
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_t;

   // ---------------------------------------------------------------------------
   // Synchronisers and fall strobe
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] ws_sync_q;
   logic                   sclk_prev_q;
   logic                   sclk_s;
   logic                   ws_s;
   logic                   fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_q <= '0;
         ws_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], ws};
         sclk_prev_q <= sclk_s;
      end
   end

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign ws_s   = ws_sync_q[SYNC_STAGES-1];
   // sclk_prev_q resets low, so an sclk pin idling high never fakes a fall.
   assign fall   = sclk_prev_q & ~sclk_s;

   // ---------------------------------------------------------------------------
   // Sample FIFO: pointers carry a wrap bit so full and empty are distinct
   // ---------------------------------------------------------------------------
   logic [2*WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]      wptr_q;
   logic [PW-1:0]      rptr_q;
   logic               empty;
   logic               full;
   logic               push;
   logic               pop;
   logic [WIDTH-1:0]   head_l;
   logic [WIDTH-1:0]   head_r;

   assign empty    = (wptr_q == rptr_q);
   assign full     = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign in_ready = ~full;
   assign push     = in_valid & ~full;
   assign {head_l, head_r} = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= {in_data_l, in_data_r};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Transmit FSM
   // ---------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] hold_r_q, hold_r_d;
   logic             ws_prev_q, ws_prev_d;
   logic             sd_tx_q, sd_tx_d;
   logic             frame_start_q, frame_start_d;
   logic             underrun_q, underrun_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] new_l;
   logic [WIDTH-1:0] new_r;
   logic             left_start;
   logic             right_start;

   // Only meaningful when qualified by fall.
   assign left_start  = ws_prev_q & ~ws_s;
   assign right_start = ~ws_prev_q & ws_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         shreg_q       <= '0;
         hold_r_q      <= '0;
         ws_prev_q     <= 1'b0;
         sd_tx_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         hold_r_q      <= hold_r_d;
         ws_prev_q     <= ws_prev_d;
         sd_tx_q       <= sd_tx_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      hold_r_d      = hold_r_q;
      ws_prev_d     = ws_prev_q;
      sd_tx_d       = sd_tx_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      cnt_d         = cnt_q;
      pop           = 1'b0;
      new_l         = '0;
      new_r         = '0;

      if (fall) begin
         cnt_d     = '0;
         ws_prev_d = ws_s;

         unique case (state_q)
            StIdle: begin
               sd_tx_d = 1'b0;
               if (left_start) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               // Default shift; a word load below overrides shreg_d.
               sd_tx_d = shreg_q[WIDTH-1];
               shreg_d = shreg_q << 1;
            end
         endcase

         if (left_start) begin
            frame_start_d = 1'b1;
            if (empty) begin
               // Send silence rather than repeating stale data.
               underrun_d = 1'b1;
            end else begin
               pop   = 1'b1;
               new_l = head_l;
               new_r = head_r;
            end
            hold_r_d = new_r;
`ifdef I2S_SLAVE_TX_LJ_EN
            sd_tx_d = new_l[WIDTH-1];
            shreg_d = new_l << 1;
`else
            // Old word's next bit goes out now; new MSB on the following fall.
            shreg_d = new_l;
`endif
         end else if (right_start && (state_q == StRun)) begin
`ifdef I2S_SLAVE_TX_LJ_EN
            sd_tx_d = hold_r_q[WIDTH-1];
            shreg_d = hold_r_q << 1;
`else
            shreg_d = hold_r_q;
`endif
         end
      end else begin
         // Saturating count of clk cycles since the last fall.
         if (cnt_q != TO_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (cnt_q == TO_LAST) begin
            // Master has stopped; drop back and wait for a fresh left start.
            // FIFO contents are deliberately kept.
            state_d  = StIdle;
            sd_tx_d  = 1'b0;
            shreg_d  = '0;
            hold_r_d = '0;
         end
      end
   end

   assign sd_tx       = sd_tx_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
   assign active      = (state_q == StRun);

endmodule

// File: tb/tb_i2s_slave_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_slave_transmitter
//
// Bench for i2s_slave_transmitter (WIDTH=8, FIFO_DEPTH=4, sclk=clk/16, 16-bit
// slots). An I2S master model drives sclk/ws and captures sd_tx on rising sclk.
// Accepted pairs go into a scoreboard queue; each captured left slot pops the
// next pair, or expects silence when the queue is empty. The bench follows the
// DUT's I2S_SLAVE_TX_LJ_EN setting for the expected slot layout.
// -----------------------------------------------------------------------------
module tb_i2s_slave_transmitter;

   localparam int WIDTH = 8;
   localparam int HALF  = 80;  // half sclk period = 8 clk periods
`ifdef I2S_SLAVE_TX_LJ_EN
   localparam bit LJ = 1'b1;
`else
   localparam bit LJ = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sclk = 1'b1;
   logic             ws = 1'b1;
   logic             sd_tx;
   logic [WIDTH-1:0] in_data_l = '0;
   logic [WIDTH-1:0] in_data_r = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             frame_start;
   logic             underrun;
   logic             active;

   int n_cmp = 0;
   int n_err = 0;
   int fs_cnt = 0;
   int ur_cnt = 0;

   logic [15:0] exp_q[$];  // {left, right} pairs accepted by the DUT
   logic [15:0] cap_q[$];  // captured 16-bit slots: preamble, then L/R per frame

   i2s_slave_transmitter #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (4),
      .SYNC_STAGES(2),
      .TIMEOUT    (256)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .ws         (ws),
      .sd_tx      (sd_tx),
      .in_data_l  (in_data_l),
      .in_data_r  (in_data_r),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .frame_start(frame_start),
      .underrun   (underrun),
      .active     (active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (frame_start === 1'b1) fs_cnt <= fs_cnt + 1;
      if (underrun === 1'b1) ur_cnt <= ur_cnt + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Expected 16-bit slot as captured MSB-first, one bit per rising sclk.
   function automatic logic [15:0] slot_word(input logic [7:0] w);
      if (LJ) return {w, 8'h00};
      return {1'b0, w, 7'h00};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      sclk = 1'b1;
      ws = 1'b1;
      exp_q.delete();
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic push_pair(input logic [7:0] l, input logic [7:0] r);
      int n;
      n = 0;
      @(negedge clk);
      in_data_l = l;
      in_data_r = r;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_accept: in_ready=%b, required 1 within bound", in_ready);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         exp_q.push_back({l, r});
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic sclk_cycle(input logic w, output logic b);
      sclk = 1'b0;
      ws = w;
      #HALF;
      sclk = 1'b1;
      b = sd_tx;
      #HALF;
   endtask

   // One 16-cycle right-channel preamble, then nf stereo frames.
   task automatic run_master(input int nf);
      logic        b;
      logic [15:0] v;
      cap_q.delete();
      for (int s = 0; s < 1 + 2 * nf; s++) begin
         v = '0;
         for (int k = 0; k < 16; k++) begin
            sclk_cycle((s % 2 == 0), b);
            v = {v[14:0], b};
         end
         cap_q.push_back(v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (sd_tx !== 1'b0) begin n_err++; $display("FAIL reset_sd_tx: got %b required 0", sd_tx); end
      n_cmp++;
      if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b required 0", active); end
      n_cmp++;
      if (frame_start !== 1'b0) begin
         n_err++; $display("FAIL reset_frame_start: got %b required 0", frame_start);
      end
      n_cmp++;
      if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b required 0", underrun); end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Single pair, two frames: second frame underruns to silence.
   task automatic test_basic_frames();
      logic [15:0] pair, e;
      int fs0, ur0;
      pair = '0;
      do_reset();
      push_pair(8'hA5, 8'h3C);
      fs0 = fs_cnt;
      ur0 = ur_cnt;
      run_master(2);
      for (int s = 0; s < cap_q.size(); s++) begin
         if (s == 0) e = '0;
         else if (s % 2 == 1) begin
            pair = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
            e = slot_word(pair[15:8]);
         end else e = slot_word(pair[7:0]);
         n_cmp++;
         if (cap_q[s] !== e) begin n_err++; $display("FAIL basic_slot%0d: got %h required %h", s, cap_q[s], e); end
      end
      @(negedge clk);
      n_cmp++;
      if (fs_cnt - fs0 != 2) begin n_err++; $display("FAIL basic_frame_starts: got %0d required 2", fs_cnt - fs0); end
      n_cmp++;
      if (ur_cnt - ur0 != 1) begin n_err++; $display("FAIL basic_underruns: got %0d required 1", ur_cnt - ur0); end
      n_cmp++;
      if (active !== 1'b1) begin n_err++; $display("FAIL basic_active: got %b required 1", active); end
   endtask

   // Fill the FIFO, hold off a fifth pair, release it with the first pop.
   task automatic test_back_to_back();
      logic [15:0] pair, e;
      int fs0, ur0, nw;
      pair = '0;
      do_reset();
      for (int i = 1; i <= 4; i++) push_pair(8'(8'h10 + i), 8'(8'hE0 + i));
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b required 0", in_ready); end
      fs0 = fs_cnt;
      ur0 = ur_cnt;
      nw = 0;
      fork
         push_pair(8'h15, 8'hE5);
         run_master(5);
         begin
            while (frame_start !== 1'b1 && nw < 2000) begin
               @(negedge clk);
               nw++;
            end
            n_cmp++;
            if (frame_start !== 1'b1 || in_ready !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_ready_after_pop: frame_start=%b in_ready=%b required 1/1", frame_start,
                        in_ready);
            end
         end
      join
      for (int s = 0; s < cap_q.size(); s++) begin
         if (s == 0) e = '0;
         else if (s % 2 == 1) begin
            pair = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
            e = slot_word(pair[15:8]);
         end else e = slot_word(pair[7:0]);
         n_cmp++;
         if (cap_q[s] !== e) begin n_err++; $display("FAIL b2b_slot%0d: got %h required %h", s, cap_q[s], e); end
      end
      @(negedge clk);
      n_cmp++;
      if (fs_cnt - fs0 != 5) begin n_err++; $display("FAIL b2b_frame_starts: got %0d required 5", fs_cnt - fs0); end
      n_cmp++;
      if (ur_cnt - ur0 != 0) begin n_err++; $display("FAIL b2b_underruns: got %0d required 0", ur_cnt - ur0); end
   endtask

   task automatic test_underrun();
      int fs0, ur0;
      do_reset();
      fs0 = fs_cnt;
      ur0 = ur_cnt;
      run_master(3);
      for (int s = 0; s < cap_q.size(); s++) begin
         n_cmp++;
         if (cap_q[s] !== 16'h0000) begin
            n_err++; $display("FAIL underrun_slot%0d: got %h required 0000", s, cap_q[s]);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (ur_cnt - ur0 != 3) begin n_err++; $display("FAIL underrun_pulses: got %0d required 3", ur_cnt - ur0); end
      n_cmp++;
      if (fs_cnt - fs0 != 3) begin n_err++; $display("FAIL underrun_frames: got %0d required 3", fs_cnt - fs0); end
   endtask

   // Reset in the middle of the left word while bit 3 is on the line.
   task automatic test_mid_word_reset();
      logic        b, any;
      logic [15:0] pair, e;
      int kstop;
      pair = '0;
      do_reset();
      push_pair(8'h5A, 8'hC3);
      for (int k = 0; k < 16; k++) sclk_cycle(1'b1, b);
      kstop = LJ ? 4 : 5;
      for (int k = 0; k < kstop; k++) sclk_cycle(1'b0, b);
      sclk = 1'b0;
      ws = 1'b0;
      #HALF;
      sclk = 1'b1;
      n_cmp++;
      if (sd_tx !== 1'b1) begin n_err++; $display("FAIL midrst_bit3: got %b required 1", sd_tx); end
      #40;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (sd_tx !== 1'b0) begin n_err++; $display("FAIL midrst_sd_tx: got %b required 0", sd_tx); end
      n_cmp++;
      if (active !== 1'b0) begin n_err++; $display("FAIL midrst_active: got %b required 0", active); end
      #39;
      rst = 1'b1;
      exp_q.delete();
      any = 1'b0;
      for (int k = kstop + 1; k < 16; k++) begin
         sclk_cycle(1'b0, b);
         any = any | (b !== 1'b0);
      end
      n_cmp++;
      if (any !== 1'b0) begin n_err++; $display("FAIL midrst_quiet: got activity=%b required 0", any); end
      push_pair(8'h96, 8'h69);
      run_master(1);
      for (int s = 0; s < cap_q.size(); s++) begin
         if (s == 0) e = '0;
         else if (s % 2 == 1) begin
            pair = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
            e = slot_word(pair[15:8]);
         end else e = slot_word(pair[7:0]);
         n_cmp++;
         if (cap_q[s] !== e) begin n_err++; $display("FAIL midrst_slot%0d: got %h required %h", s, cap_q[s], e); end
      end
   endtask

   // Stop sclk long enough to time out, then restart mid right slot.
   task automatic test_timeout();
      logic        b, any;
      logic [15:0] pair, e;
      int n;
      pair = '0;
      do_reset();
      push_pair(8'hC7, 8'h18);
      run_master(1);
      for (int s = 0; s < cap_q.size(); s++) begin
         if (s == 0) e = '0;
         else if (s % 2 == 1) begin
            pair = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
            e = slot_word(pair[15:8]);
         end else e = slot_word(pair[7:0]);
         n_cmp++;
         if (cap_q[s] !== e) begin n_err++; $display("FAIL tmo_slot%0d: got %h required %h", s, cap_q[s], e); end
      end
      #1;
      n_cmp++;
      if (active !== 1'b1) begin n_err++; $display("FAIL tmo_active_before: got %b required 1", active); end
      // Last pin fall was 16 clk ago; 3 clk sync + 256 clk count puts the drop ~243 clk out.
      n = 0;
      while (active === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n < 241 || n > 245) begin
         n_err++; $display("FAIL tmo_delay: active fell after %0d clk, required 241..245", n);
      end
      repeat (300 - n) @(negedge clk);
      n_cmp++;
      if (sd_tx !== 1'b0 || active !== 1'b0) begin
         n_err++; $display("FAIL tmo_idle: sd_tx=%b active=%b required 0/0", sd_tx, active);
      end
      push_pair(8'h3E, 8'hD4);
      any = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sclk_cycle(1'b1, b);
         any = any | (b !== 1'b0);
      end
      n_cmp++;
      if (any !== 1'b0 || active !== 1'b0) begin
         n_err++; $display("FAIL tmo_restart_idle: activity=%b active=%b required 0/0", any, active);
      end
      run_master(1);
      for (int s = 0; s < cap_q.size(); s++) begin
         if (s == 0) e = '0;
         else if (s % 2 == 1) begin
            pair = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
            e = slot_word(pair[15:8]);
         end else e = slot_word(pair[7:0]);
         n_cmp++;
         if (cap_q[s] !== e) begin n_err++; $display("FAIL tmo_re_slot%0d: got %h required %h", s, cap_q[s], e); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frames();
      test_back_to_back();
      test_underrun();
      test_mid_word_reset();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
